clock_set_ctrl: RTL and testbench

//  Time-setting sequencer for the Clock block. Turns two raw push-buttons (MODE, UP) into the

---
 rtl/clock_set_ctrl_pkg.sv | 20 ++
 rtl/clock_set_ctrl_debouncer.sv | 33 +++
 rtl/clock_set_ctrl.sv | 106 ++++++++++
 tb/tb_clock_set_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: select codes, state encodings and cycle-count helpers for the time setter
package clock_set_ctrl_pkg;
  localparam logic [1:0] SELECT_SEC  = 2'd0;
  localparam logic [1:0] SELECT_MIN  = 2'd1;
  localparam logic [1:0] SELECT_HOUR = 2'd2;
  localparam logic [1:0] SELECT_NONE = 2'd3;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HOUR = 2'd1, ST_MIN = 2'd2, ST_SEC = 2'd3} state_t;
  function automatic logic [31:0] ms_to_cyc(input longint unsigned freq_hz, input longint unsigned ms);
    longint unsigned c;
    c = freq_hz * ms / 64'd1000;
    return (c == 64'd0) ? 32'd1 : c[31:0];
  endfunction
  function automatic state_t next_mode(input state_t s);
    return (s == ST_RUN) ? ST_HOUR : (s == ST_HOUR) ? ST_MIN : (s == ST_MIN) ? ST_SEC : ST_RUN;
  endfunction
  function automatic logic [1:0] select_of(input state_t s);
    return (s == ST_HOUR) ? SELECT_HOUR : (s == ST_MIN) ? SELECT_MIN :
           (s == ST_SEC) ? SELECT_SEC : SELECT_NONE;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_debouncer.sv
// button_debouncer: synchronises a raw button and accepts a new level only after it has been stable
module button_debouncer #(
  parameter logic [31:0] DEBOUNCE_CYC = 32'd20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  logic r_s1, r_s2, r_level, r_press;
  logic [31:0] r_cnt;
  logic w_flip;
  assign w_flip  = (r_s2 != r_level) && (r_cnt + 32'd1 == DEBOUNCE_CYC);
  assign o_level = r_level;
  assign o_press = r_press;
  // two-flop synchroniser, stability counter and level/press registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= 32'd0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_cnt   <= (r_s2 != r_level && !w_flip) ? r_cnt + 32'd1 : 32'd0;
      r_level <= w_flip ? ~r_level : r_level;
      r_press <= w_flip && !r_level;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: turns MODE/UP buttons into field select, increment pulses and blink for the Clock
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 1000,
  parameter int unsigned DEBOUNCE_MS      = 20,
  parameter int unsigned REPEAT_DELAY_MS  = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 100,
  parameter int unsigned TIMEOUT_S        = 10,
  parameter int unsigned BLINK_HZ         = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic [1:0] o_select,
  output logic       o_increment,
  output logic       o_editing,
  output logic       o_blink
);
  localparam logic [31:0] DEBOUNCE_CYC      = ms_to_cyc(64'(CLK_FREQ_HZ), 64'(DEBOUNCE_MS));
  localparam logic [31:0] REPEAT_DELAY_CYC  = ms_to_cyc(64'(CLK_FREQ_HZ), 64'(REPEAT_DELAY_MS));
  localparam logic [31:0] REPEAT_PERIOD_CYC = ms_to_cyc(64'(CLK_FREQ_HZ), 64'(REPEAT_PERIOD_MS));
  localparam logic [31:0] TIMEOUT_CYC       = CLK_FREQ_HZ * TIMEOUT_S;
  localparam logic [31:0] BLINK_HALF        = CLK_FREQ_HZ / (2 * BLINK_HZ);

  logic w_mode_p, w_mode_level_unused, w_up_p, w_up_lvl;
  logic w_edit, w_up_ok, w_rep_hit, w_inc_now, w_clr, w_timeout, w_bl_wrap;
  state_t w_next;
  state_t r_state;
  logic [1:0] r_select;
  logic r_increment, r_editing, r_blink, r_armed, r_first;
  logic [31:0] r_rep, r_to, r_bl_cnt;

  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_btn_mode), .o_level(w_mode_level_unused), .o_press(w_mode_p)
  );
  button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_btn_up), .o_level(w_up_lvl), .o_press(w_up_p)
  );

  // MODE always beats UP in the same cycle; a discarded UP press never arms auto-repeat
  assign w_edit    = r_state != ST_RUN;
  assign w_up_ok   = w_up_p && !w_mode_p && w_edit;
  assign w_rep_hit = r_armed && w_up_lvl && !w_mode_p &&
                     (r_rep + 32'd1 == (r_first ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC));
  assign w_inc_now = w_up_ok || (w_edit && w_rep_hit);
  assign w_clr     = w_mode_p || w_up_p || w_inc_now;
  assign w_timeout = w_edit && !w_clr && (r_to + 32'd1 == TIMEOUT_CYC);
  assign w_next    = w_mode_p ? next_mode(r_state) : w_timeout ? ST_RUN : r_state;
  assign w_bl_wrap = r_bl_cnt + 32'd1 == BLINK_HALF;

  assign o_select    = r_select;
  assign o_increment = r_increment;
  assign o_editing   = r_editing;
  assign o_blink     = r_blink;

  // auto-repeat: r_rep counts cycles since the last UP pulse while the held press stays armed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
      r_first <= 1'b0;
      r_rep   <= 32'd0;
    end else if (w_mode_p || !w_up_lvl || w_timeout) begin
      r_armed <= 1'b0;
      r_first <= 1'b0;
      r_rep   <= 32'd0;
    end else if (w_up_ok) begin
      r_armed <= 1'b1;
      r_first <= 1'b1;
      r_rep   <= 32'd1;
    end else if (w_rep_hit) begin
      r_first <= 1'b0;
      r_rep   <= 32'd0;
    end else begin
      r_rep   <= r_armed ? r_rep + 32'd1 : 32'd0;
    end
  end

  // idle counter: holds cycles elapsed since the last press or increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_to <= 32'd0;
    else          r_to <= w_clr ? 32'd1 : r_to + 32'd1;
  end

  // mode FSM with registered select/editing/increment and the blink phase of the edited field
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_select    <= SELECT_NONE;
      r_editing   <= 1'b0;
      r_increment <= 1'b0;
      r_blink     <= 1'b0;
      r_bl_cnt    <= 32'd0;
    end else begin
      r_state     <= w_next;
      r_select    <= select_of(w_next);
      r_editing   <= w_next != ST_RUN;
      r_increment <= w_inc_now;
      r_blink     <= (w_next == ST_RUN) ? 1'b0 : (w_next != r_state || w_inc_now) ? 1'b1 :
                     w_bl_wrap ? ~r_blink : r_blink;
      r_bl_cnt    <= (w_next == ST_RUN || w_next != r_state || w_inc_now || w_bl_wrap) ? 32'd0 :
                     r_bl_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for the time-setting sequencer with a tiny Clock model
module tb_clock_set_ctrl;
  typedef struct {
    int         at;
    logic [1:0] sel;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, btn_up = 1'b0;
  logic [1:0] sel;
  logic inc, editing, blink;
  int total = 0, bad = 0, cyc = 0;
  int hour = 0, minute = 0, second = 0;
  exp_t sb[$];

  clock_set_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_mode(btn_mode), .i_btn_up(btn_up),
    .o_select(sel), .o_increment(inc), .o_editing(editing), .o_blink(blink)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every increment must match the next scoreboard entry in cycle and field; also drives the Clock model
  always @(negedge clk) begin
    exp_t e;
    if (inc) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_increment cyc=%0d sel=%0d, required no pulse", cyc, sel);
      end else begin
        e = sb.pop_front();
        if (e.at != cyc || e.sel !== sel) begin
          bad++;
          $display("FAIL increment_timing got cyc=%0d sel=%0d, required cyc=%0d sel=%0d", cyc, sel, e.at, e.sel);
        end
      end
      if (sel == 2'd2) hour = (hour + 1) % 24;
      else if (sel == 2'd1) minute = (minute + 1) % 60;
      else if (sel == 2'd0) second = 0;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic mode_press(output int c);
    @(negedge clk);
    c = cyc;
    btn_mode = 1'b1;
    repeat (40) @(negedge clk);
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sel, inc, editing, blink} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=11000", {sel, inc, editing, blink});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_debounce();
    int l;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      btn_mode = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    btn_mode = 1'b1;
    l = cyc;
    wait_to(l + 22);
    total++;
    if (sel !== 2'd3 || editing !== 1'b0) begin
      bad++;
      $display("FAIL bounce_early got sel=%0d ed=%0d, required sel=3 ed=0", sel, editing);
    end
    wait_to(l + 23);
    total++;
    if (sel !== 2'd2 || editing !== 1'b1) begin
      bad++;
      $display("FAIL bounce_accept got sel=%0d ed=%0d, required sel=2 ed=1", sel, editing);
    end
    wait_to(l + 150);
    total++;
    if (sel !== 2'd2) begin
      bad++;
      $display("FAIL bounce_single got sel=%0d, required 2", sel);
    end
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_sel[4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic       exp_ed[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    int c;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c = cyc;
      btn_mode = 1'b1;
      wait_to(c + 23);
      total++;
      if (sel !== exp_sel[i] || editing !== exp_ed[i]) begin
        bad++;
        $display("FAIL mode_step%0d got sel=%0d ed=%0d, required sel=%0d ed=%0d", i, sel, editing, exp_sel[i], exp_ed[i]);
      end
      wait_to(c + 40);
      btn_mode = 1'b0;
      wait_to(c + 80);
    end
  endtask

  task automatic test_blink();
    int c, s;
    @(negedge clk);
    c = cyc;
    btn_mode = 1'b1;
    s = c + 23;
    wait_to(s);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_enter got=%b required=1", blink); end
    wait_to(c + 40);
    btn_mode = 1'b0;
    wait_to(s + 249);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_half_end got=%b required=1", blink); end
    wait_to(s + 250);
    total++;
    if (blink !== 1'b0) begin bad++; $display("FAIL blink_toggle got=%b required=0", blink); end
    btn_up = 1'b1;
    sb.push_back('{s + 273, 2'd2});
    wait_to(s + 272);
    total++;
    if (blink !== 1'b0) begin bad++; $display("FAIL blink_pre_inc got=%b required=0", blink); end
    wait_to(s + 273);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_forced got=%b required=1", blink); end
    wait_to(s + 310);
    btn_up = 1'b0;
    wait_to(s + 522);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_forced_end got=%b required=1", blink); end
    wait_to(s + 523);
    total++;
    if (blink !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL blink_after_inc got blink=%b pending=%0d, required blink=0 pending=0", blink, sb.size());
    end
  endtask

  task automatic test_single_inc();
    int c;
    do_reset();
    mode_press(c);
    mode_press(c);
    minute = 5;
    @(negedge clk);
    c = cyc;
    btn_up = 1'b1;
    sb.push_back('{c + 23, 2'd1});
    repeat (100) @(negedge clk);
    btn_up = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if (sb.size() != 0 || minute != 6) begin
      bad++;
      $display("FAIL single_inc got pending=%0d min=%0d, required pending=0 min=6", sb.size(), minute);
    end
  endtask

  task automatic test_repeat();
    int c, p;
    int offs[6] = '{1, 500, 600, 700, 800, 900};
    do_reset();
    mode_press(c);
    hour = 22;
    @(negedge clk);
    c = cyc;
    p = c + 22;
    btn_up = 1'b1;
    foreach (offs[i]) sb.push_back('{p + offs[i], 2'd2});
    wait_to(p + 950);
    btn_up = 1'b0;
    wait_to(p + 1100);
    total++;
    if (sb.size() != 0 || hour != 4) begin
      bad++;
      $display("FAIL auto_repeat got pending=%0d hour=%0d, required pending=0 hour=4", sb.size(), hour);
    end
  endtask

  task automatic test_timeout_and_tie();
    int c;
    do_reset();
    mode_press(c);
    mode_press(c);
    mode_press(c);
    wait_to(c + 10021);
    total++;
    if (editing !== 1'b1 || sel !== 2'd0) begin
      bad++;
      $display("FAIL timeout_early got sel=%0d ed=%0d, required sel=0 ed=1", sel, editing);
    end
    wait_to(c + 10022);
    total++;
    if (editing !== 1'b0 || sel !== 2'd3) begin
      bad++;
      $display("FAIL timeout_fall got sel=%0d ed=%0d, required sel=3 ed=0", sel, editing);
    end
    mode_press(c);
    mode_press(c);
    @(negedge clk);
    c = cyc;
    btn_mode = 1'b1;
    btn_up = 1'b1;
    wait_to(c + 23);
    total++;
    if (sel !== 2'd0 || inc !== 1'b0) begin
      bad++;
      $display("FAIL mode_up_tie got sel=%0d inc=%b, required sel=0 inc=0", sel, inc);
    end
    wait_to(c + 700);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (sel !== 2'd0) begin bad++; $display("FAIL tie_state got sel=%0d required=0", sel); end
  endtask

  task automatic test_reset_repeat();
    int c, p;
    do_reset();
    mode_press(c);
    @(negedge clk);
    c = cyc;
    p = c + 22;
    btn_up = 1'b1;
    sb.push_back('{p + 1, 2'd2});
    sb.push_back('{p + 500, 2'd2});
    wait_to(p + 550);
    total++;
    if (sb.size() != 0 || sel !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset got pending=%0d sel=%0d, required pending=0 sel=2", sb.size(), sel);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, inc, editing, blink} !== 5'b11000) begin
      bad++;
      $display("FAIL async_reset got=%b required=11000", {sel, inc, editing, blink});
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    total++;
    if (editing !== 1'b0) begin bad++; $display("FAIL post_reset_run got ed=%b required=0", editing); end
    mode_press(c);
    repeat (600) @(negedge clk);
    btn_up = 1'b0;
    repeat (40) @(negedge clk);
    c = cyc;
    btn_up = 1'b1;
    sb.push_back('{c + 23, 2'd2});
    repeat (60) @(negedge clk);
    btn_up = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL repress_inc got pending=%0d required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mode_cycle();
    test_blink();
    test_single_inc();
    test_repeat();
    test_timeout_and_tie();
    test_reset_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
